wr_arb_4ch: RTL and testbench

//  Round-robin write-channel arbiter in the ddr_clk domain, directly downstream of the four
//  per-channel line write buffers (wr_buf_0..3). Merges four ddr_wreq/ddr_waddr/ddr_wr_len/
//  ddr_wdata channels onto the single write port of the DDR write controller. Routes the

---
 rtl/wr_arb_4ch.sv | 151 +++++++++++++++
 tb/tb_wr_arb_4ch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_arb_4ch.sv
// Round-robin arbiter merging four line-buffer write channels onto one DDR write port.
// Optional per-channel burst counters are enabled by defining WR_ARB_STAT_EN.
module wr_arb_4ch #(
  parameter int ADDR_WIDTH = 27,
  parameter int LEN_WIDTH  = 16,
  parameter int DQ_WIDTH   = 16
) (
  input  logic                        ddr_clk,
  input  logic                        ddr_rst,
  input  logic [3:0]                  ch_wreq,
  input  logic [4*ADDR_WIDTH-1:0]     ch_waddr,
  input  logic [4*LEN_WIDTH-1:0]      ch_wr_len,
  input  logic [4*8*DQ_WIDTH-1:0]     ch_wdata,
  output logic [3:0]                  ch_wrdy,
  output logic [3:0]                  ch_wdata_req,
  output logic [3:0]                  ch_wdone,
  output logic                        ddr_wreq,
  output logic [ADDR_WIDTH-1:0]       ddr_waddr,
  output logic [LEN_WIDTH-1:0]        ddr_wr_len,
  output logic [8*DQ_WIDTH-1:0]       ddr_wdata,
  input  logic                        ddr_wrdy,
  input  logic                        ddr_wdata_req,
  input  logic                        ddr_wdone,
  output logic [1:0]                  arb_gnt
`ifdef WR_ARB_STAT_EN
  ,
  input  logic                        stat_clr,
  output logic [63:0]                 ch_burst_cnt
`endif
);

  localparam int DW = 8 * DQ_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] gnt_nxt;

  // First requesting channel after the last grant; iterating downward lets the nearest win.
  function automatic logic [1:0] pick_next(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    pick_next = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + k[1:0];
      if (req[idx]) begin
        pick_next = idx;
      end else begin
        pick_next = pick_next;
      end
    end
  endfunction

  // Next-state and next-grant decision
  always_comb begin
    state_nxt = state;
    gnt_nxt   = arb_gnt;
    case (state)
      IDLE: begin
        if (ch_wreq != 4'b0000) begin
          state_nxt = REQ;
          gnt_nxt   = pick_next(ch_wreq, arb_gnt);
        end else begin
          state_nxt = IDLE;
        end
      end
      REQ: begin
        if (ddr_wdata_req) begin
          state_nxt = DATA;
        end else begin
          state_nxt = REQ;
        end
      end
      DATA: begin
        if (ddr_wdone) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DATA;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant and latched burst descriptor
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      state      <= IDLE;
      arb_gnt    <= 2'd3;
      ddr_wreq   <= 1'b0;
      ddr_waddr  <= {ADDR_WIDTH{1'b0}};
      ddr_wr_len <= {LEN_WIDTH{1'b0}};
    end else begin
      state    <= state_nxt;
      arb_gnt  <= gnt_nxt;
      ddr_wreq <= (state_nxt == REQ);
      if ((state == IDLE) && (ch_wreq != 4'b0000)) begin
        ddr_waddr  <= ch_waddr[gnt_nxt*ADDR_WIDTH +: ADDR_WIDTH];
        ddr_wr_len <= ch_wr_len[gnt_nxt*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  // Zero-latency return routing: the buffer steps its read pointer in the data-request cycle
  always_comb begin
    ch_wrdy      = 4'b0000;
    ch_wdata_req = 4'b0000;
    ch_wdone     = 4'b0000;
    if (state != IDLE) begin
      ch_wrdy[arb_gnt]      = ddr_wrdy;
      ch_wdata_req[arb_gnt] = ddr_wdata_req;
      if (state == DATA) begin
        ch_wdone[arb_gnt] = ddr_wdone;
      end else begin
        ch_wdone = 4'b0000;
      end
    end else begin
      ch_wrdy      = 4'b0000;
      ch_wdata_req = 4'b0000;
      ch_wdone     = 4'b0000;
    end
  end

  assign ddr_wdata = ch_wdata[arb_gnt*DW +: DW];

`ifdef WR_ARB_STAT_EN
  logic [3:0][15:0] burst_cnt;

  // Completed-burst counters, wrapping at 16 bits
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      burst_cnt <= {4{16'h0000}};
    end else if (stat_clr) begin
      burst_cnt <= {4{16'h0000}};
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ch_wdone[i]) begin
          burst_cnt[i] <= burst_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign ch_burst_cnt = burst_cnt;
`endif

endmodule

// File: tb/tb_wr_arb_4ch.sv
// Self-checking bench for wr_arb_4ch: directed vector table, burst sequences,
// and randomized traffic against a transaction-level round-robin model.
module tb_wr_arb_4ch;

  localparam int AW = 27;
  localparam int LW = 16;
  localparam int DW = 128;

  logic            ddr_clk = 1'b0;
  logic            ddr_rst = 1'b1;
  logic [3:0]      ch_wreq = 4'b0000;
  logic [4*AW-1:0] ch_waddr = '0;
  logic [4*LW-1:0] ch_wr_len = '0;
  logic [4*DW-1:0] ch_wdata = '0;
  logic [3:0]      ch_wrdy, ch_wdata_req, ch_wdone;
  logic            ddr_wreq;
  logic [AW-1:0]   ddr_waddr;
  logic [LW-1:0]   ddr_wr_len;
  logic [DW-1:0]   ddr_wdata;
  logic            ddr_wrdy = 1'b0;
  logic            ddr_wdata_req = 1'b0;
  logic            ddr_wdone = 1'b0;
  logic [1:0]      arb_gnt;
`ifdef WR_ARB_STAT_EN
  logic            stat_clr = 1'b0;
  logic [63:0]     ch_burst_cnt;
`endif

  int checks = 0;
  int errors = 0;

  wr_arb_4ch dut (
    .ddr_clk(ddr_clk), .ddr_rst(ddr_rst), .ch_wreq(ch_wreq), .ch_waddr(ch_waddr),
    .ch_wr_len(ch_wr_len), .ch_wdata(ch_wdata), .ch_wrdy(ch_wrdy),
    .ch_wdata_req(ch_wdata_req), .ch_wdone(ch_wdone), .ddr_wreq(ddr_wreq),
    .ddr_waddr(ddr_waddr), .ddr_wr_len(ddr_wr_len), .ddr_wdata(ddr_wdata),
    .ddr_wrdy(ddr_wrdy), .ddr_wdata_req(ddr_wdata_req), .ddr_wdone(ddr_wdone),
    .arb_gnt(arb_gnt)
`ifdef WR_ARB_STAT_EN
    , .stat_clr(stat_clr), .ch_burst_cnt(ch_burst_cnt)
`endif
  );

  always #5 ddr_clk = ~ddr_clk;

  task automatic tick;
    @(posedge ddr_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic randomize_data;
    for (int k = 0; k < 16; k++) ch_wdata[k*32 +: 32] = $urandom;
  endtask

  // One burst on the expected channel: wait for the request, stream beats, finish.
  task automatic do_burst(input int g, input int beats);
    int waited = 0;
    ddr_wdata_req = 1'b0;
    ddr_wdone = 1'b0;
    #1;
    while (!ddr_wreq && waited < 8) begin
      tick();
      waited++;
    end
    chk("burst_wreq", ddr_wreq, 1'b1);
    chk("burst_gnt", arb_gnt, g);
    for (int b = 0; b < beats; b++) begin
      randomize_data();
      ddr_wdata_req = 1'b1;
      #1;
      chk("beat_data", ddr_wdata, ch_wdata[g*DW +: DW]);
      chk("beat_req", ch_wdata_req, 4'b0001 << g);
      tick();
    end
    ddr_wdata_req = 1'b0;
    ddr_wdone = 1'b1;
    #1;
    chk("burst_done", ch_wdone, 4'b0001 << g);
    tick();
    ddr_wdone = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] wreq;
    logic       wdreq;
    logic       wdone;
    logic       chk_en;
    logic       e_wreq;
    logic [1:0] e_gnt;
    logic [3:0] e_cwdreq;
    logic [3:0] e_cwdone;
  } vec_t;

  vec_t vt[20];

  // Random-phase reference model state
  int         ph;
  int         last;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_len;
  int         wait_cnt[4];
  logic       prev_wreq;

  initial begin
    // rst wreq wdreq wdone chk | e_wreq e_gnt e_cwdreq e_cwdone
    vt[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000};
    vt[1]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0000, 4'b0000};
    vt[2]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0000, 4'b0000};
    vt[3]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0000};
    vt[4]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0001, 4'b0000};
    vt[5]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0001};
    vt[6]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000};
    vt[7]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000};
    vt[8]  = '{1'b0, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0000, 4'b0000};
    vt[9]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0010, 4'b0000};
    vt[10] = '{1'b0, 4'b0100, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0000, 4'b0010};
    vt[11] = '{1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0000, 4'b0000};
    vt[12] = '{1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0000, 4'b0000};
    vt[13] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0100, 4'b0000};
    vt[14] = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0100, 4'b0000};
    vt[15] = '{1'b0, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 4'b0000, 4'b0000};
    vt[16] = '{1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 4'b0000, 4'b0000};
    vt[17] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 4'b1000, 4'b0000};
    vt[18] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 4'b0000, 4'b1000};
    vt[19] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0000, 4'b0000};

    for (int i = 0; i < 4; i++) begin
      ch_waddr[i*AW +: AW]  = AW'(32'h100 * (i + 1));
      ch_wr_len[i*LW +: LW] = LW'(160 + i);
      ch_wdata[i*DW +: DW]  = {4{32'hA5A5_0000 + i}};
    end

    // Directed vector table
    tick();
    for (int v = 0; v < 20; v++) begin
      ddr_rst       = vt[v].rst;
      ch_wreq       = vt[v].wreq;
      ddr_wdata_req = vt[v].wdreq;
      ddr_wrdy      = vt[v].wdreq;
      ddr_wdone     = vt[v].wdone;
      #1;
      if (vt[v].chk_en) begin
        chk("vec_wreq", ddr_wreq, vt[v].e_wreq);
        chk("vec_gnt", arb_gnt, vt[v].e_gnt);
        chk("vec_wdata_req", ch_wdata_req, vt[v].e_cwdreq);
        chk("vec_wrdy", ch_wrdy, vt[v].e_cwdreq);
        chk("vec_wdone", ch_wdone, vt[v].e_cwdone);
        chk("vec_wdata", ddr_wdata, {4{32'hA5A5_0000 + 32'(vt[v].e_gnt)}});
        if (vt[v].e_wreq) begin
          chk("vec_waddr", ddr_waddr, 32'h100 * (vt[v].e_gnt + 1));
          chk("vec_wr_len", ddr_wr_len, 160 + vt[v].e_gnt);
        end
      end
      tick();
    end
    ddr_rst = 1'b0;
    ddr_wdata_req = 1'b0;
    ddr_wdone = 1'b0;
    ddr_wrdy = 1'b0;

    // Round-robin order with all channels held, then a long burst
    ddr_rst = 1'b1;
    tick();
    ddr_rst = 1'b0;
    ch_wreq = 4'b1111;
    do_burst(0, 1);
    do_burst(1, 1);
    do_burst(2, 1);
    do_burst(3, 1);
    do_burst(0, 1);
    ch_wreq = 4'b0010;
    do_burst(1, 160);

`ifdef WR_ARB_STAT_EN
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    #1;
    chk("stat_clr0", ch_burst_cnt, 64'h0);
    do_burst(1, 2);
    do_burst(1, 2);
    do_burst(1, 2);
    ch_wreq = 4'b0000;
    #1;
    chk("stat_cnt3", ch_burst_cnt, 64'h0000_0000_0003_0000);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    #1;
    chk("stat_clr1", ch_burst_cnt, 64'h0);
`endif
    ch_wreq = 4'b0000;

    // Randomized traffic against the transaction-level model
    ddr_rst = 1'b1;
    tick();
    ddr_rst = 1'b0;
    ph = 0;
    last = 3;
    m_addr = '0;
    m_len = '0;
    prev_wreq = 1'b0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic [3:0] e_cwdreq, e_cwrdy, e_cwdone;
      ddr_rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) ch_wreq = 4'($urandom);
      ddr_wrdy      = 1'($urandom);
      ddr_wdata_req = 1'($urandom);
      ddr_wdone     = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 4; i++) begin
        ch_waddr[i*AW +: AW]  = AW'($urandom);
        ch_wr_len[i*LW +: LW] = LW'($urandom);
      end
      randomize_data();
      #1;
      e_cwdreq = (ph != 0 && ddr_wdata_req) ? (4'b0001 << last) : 4'b0000;
      e_cwrdy  = (ph != 0 && ddr_wrdy) ? (4'b0001 << last) : 4'b0000;
      e_cwdone = (ph == 2 && ddr_wdone) ? (4'b0001 << last) : 4'b0000;
      chk("rnd_wreq", ddr_wreq, ph == 1);
      chk("rnd_gnt", arb_gnt, last);
      chk("rnd_wdata_req", ch_wdata_req, e_cwdreq);
      chk("rnd_wrdy", ch_wrdy, e_cwrdy);
      chk("rnd_wdone", ch_wdone, e_cwdone);
      chk("rnd_waddr", ddr_waddr, m_addr);
      chk("rnd_wr_len", ddr_wr_len, m_len);
      chk("rnd_wdata", ddr_wdata, ch_wdata[last*DW +: DW]);

      // Starvation bound observed on the DUT's own grants
      for (int i = 0; i < 4; i++) if (!ch_wreq[i]) wait_cnt[i] = 0;
      if (ddr_wreq && !prev_wreq) begin
        wait_cnt[arb_gnt] = 0;
        for (int i = 0; i < 4; i++) begin
          if (i != int'(arb_gnt) && ch_wreq[i]) begin
            wait_cnt[i]++;
            chk("starve", wait_cnt[i] > 3, 1'b0);
          end
        end
      end
      prev_wreq = ddr_wreq;

      if (ddr_rst) begin
        ph = 0;
        last = 3;
        m_addr = '0;
        m_len = '0;
        prev_wreq = 1'b0;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
      end else if (ph == 0) begin
        for (int k = 1; k <= 4; k++) begin
          if (ch_wreq[(last + k) % 4]) begin
            last = (last + k) % 4;
            m_addr = ch_waddr[last*AW +: AW];
            m_len = ch_wr_len[last*LW +: LW];
            ph = 1;
            break;
          end
        end
      end else if (ph == 1) begin
        if (ddr_wdata_req) ph = 2;
      end else begin
        if (ddr_wdone) ph = 0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
